// File: rtl/count_ctrl_pkg.sv
// Shared definitions for the count_ctrl sequencing controller and its counter core.
package count_ctrl_pkg;

  localparam int DEF_WIDTH = 3;
  localparam int DEF_OVF_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2
  } state_t;

endpackage : count_ctrl_pkg

// File: rtl/count_core.sv
// Binary counter with synchronous clear, enable and terminal-count compare.
// The count stops at limit; wrapping back to zero is the controller's decision via clr.
module count_core
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             res,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] limit,
  output logic [WIDTH-1:0] count,
  output logic             tc
);

  logic at_limit;

  assign at_limit = (count == limit);
  assign tc       = en & at_limit;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && !at_limit) begin
      count <= count + 1'b1;
    end
  end

endmodule : count_core

// File: rtl/count_ctrl.sv
// Start/stop/pause sequencer around count_core: programmable terminal count,
// one-shot or auto-reload operation, registered done pulse and saturating reload tally.
module count_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int OVF_W = DEF_OVF_W
) (
  input  logic             clk,
  input  logic             res,
  input  logic             start,
  input  logic             stop,
  input  logic             tick,
  input  logic             mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic [OVF_W-1:0] ovf_cnt
);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] limit;
  logic             mode_q;
  logic             launch;
  logic             done_set;
  logic             reload;
  logic             core_clr;
  logic             core_en;
  logic             tc;

  // Enable is decoded straight from registered state so tc never feeds back into itself.
  assign core_en = (state == ST_RUN) & tick & ~stop;

  count_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .res   (res),
    .clr   (core_clr),
    .en    (core_en),
    .limit (limit),
    .count (count),
    .tc    (tc)
  );

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt = state;
    launch    = 1'b0;
    done_set  = 1'b0;
    reload    = 1'b0;
    core_clr  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !stop) begin
          launch   = 1'b1;
          core_clr = 1'b1;
          if (load_val == '0 && !mode) begin
            done_set = 1'b1;
          end else begin
            state_nxt = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_nxt = ST_PAUSE;
        end else if (tc) begin
          done_set = 1'b1;
          if (mode_q) begin
            reload   = 1'b1;
            core_clr = 1'b1;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      ST_PAUSE: begin
        if (stop) begin
          state_nxt = ST_IDLE;
          core_clr  = 1'b1;
        end else if (start) begin
          state_nxt = ST_RUN;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Terminal value and mode are captured only at launch; pause/resume never reloads them.
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      limit   <= '0;
      mode_q  <= 1'b0;
      done    <= 1'b0;
      ovf_cnt <= '0;
    end else begin
      done <= done_set;
      if (launch) begin
        limit   <= load_val;
        mode_q  <= mode;
        ovf_cnt <= '0;
      end else if (reload && ovf_cnt != '1) begin
        ovf_cnt <= ovf_cnt + 1'b1;
      end
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_PAUSE);

endmodule : count_ctrl

// File: tb/tb_count_ctrl.sv
// Directed self-checking bench for count_ctrl (WIDTH=3, OVF_W=8).
module tb_count_ctrl;

  localparam int W  = 3;
  localparam int OW = 8;

  logic          clk;
  logic          res;
  logic          start;
  logic          stop;
  logic          tick;
  logic          mode;
  logic [W-1:0]  load_val;
  logic [W-1:0]  count;
  logic          busy;
  logic          done;
  logic [OW-1:0] ovf_cnt;

  int tests = 0;
  int fails = 0;

  count_ctrl #(.WIDTH(W), .OVF_W(OW)) dut (
    .clk      (clk),
    .res      (res),
    .start    (start),
    .stop     (stop),
    .tick     (tick),
    .mode     (mode),
    .load_val (load_val),
    .count    (count),
    .busy     (busy),
    .done     (done),
    .ovf_cnt  (ovf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  // Advance one rising edge, then settle 1 ns so inputs/outputs are away from the edge.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic launch(input logic [W-1:0] lv, input logic md);
    start    = 1'b1;
    stop     = 1'b0;
    load_val = lv;
    mode     = md;
    cyc();
    start    = 1'b0;
  endtask

  task automatic test_reset();
    tests++;
    if ({count, busy, done, ovf_cnt} !== {3'd0, 1'b0, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL reset_init: count=%0d busy=%b done=%b ovf=%0d, expected 0/0/0/0",
               count, busy, done, ovf_cnt);
    end
    res = 1'b1;
    tick = 1'b1;
    launch(3'd7, 1'b0);
    repeat (5) cyc();
    tests++;
    if (count !== 3'd5) begin
      fails++;
      $display("FAIL reset_pre: count=%0d, expected 5", count);
    end
    #2 res = 1'b0;
    #1;
    tests++;
    if ({count, busy, done, ovf_cnt} !== {3'd0, 1'b0, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL reset_mid: count=%0d busy=%b done=%b ovf=%0d, expected 0/0/0/0",
               count, busy, done, ovf_cnt);
    end
    cyc();
    res = 1'b1;
    cyc();
    tests++;
    if ({count, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL reset_after: count=%0d busy=%b done=%b, expected 0/0/0", count, busy, done);
    end
  endtask

  task automatic test_one_shot();
    tick = 1'b1;
    launch(3'd5, 1'b0);
    for (int i = 0; i <= 5; i++) begin
      tests++;
      if ({count, busy, done} !== {i[2:0], 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL oneshot_c%0d: count=%0d busy=%b done=%b, expected %0d/1/0",
                 i, count, busy, done, i);
      end
      if (i < 5) cyc();
    end
    cyc();
    tests++;
    if ({count, busy, done} !== {3'd5, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL oneshot_done: count=%0d busy=%b done=%b, expected 5/0/1", count, busy, done);
    end
    repeat (3) cyc();
    tests++;
    if ({count, busy, done} !== {3'd5, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL oneshot_hold: count=%0d busy=%b done=%b, expected 5/0/0", count, busy, done);
    end
  endtask

  task automatic test_auto_reload();
    logic [W-1:0] exp_c [0:9];
    logic         exp_d [0:9];
    logic [OW-1:0] exp_o [0:9];
    exp_c = '{3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0, 3'd1, 3'd2, 3'd0};
    exp_d = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_o = '{8'd0, 8'd0, 8'd0, 8'd1, 8'd1, 8'd1, 8'd2, 8'd2, 8'd2, 8'd3};
    tick = 1'b1;
    launch(3'd2, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tests++;
      if ({count, busy, done, ovf_cnt} !== {exp_c[i], 1'b1, exp_d[i], exp_o[i]}) begin
        fails++;
        $display("FAIL autoreload_s%0d: count=%0d busy=%b done=%b ovf=%0d, expected %0d/1/%b/%0d",
                 i, count, busy, done, ovf_cnt, exp_c[i], exp_d[i], exp_o[i]);
      end
      if (i < 9) cyc();
    end
    repeat (900) cyc();
    tests++;
    if ({count, done, ovf_cnt} !== {3'd0, 1'b1, 8'd255}) begin
      fails++;
      $display("FAIL autoreload_sat: count=%0d done=%b ovf=%0d, expected 0/1/255",
               count, done, ovf_cnt);
    end
    stop = 1'b1;
    cyc();
    cyc();
    stop = 1'b0;
    tests++;
    if ({count, busy, ovf_cnt} !== {3'd0, 1'b0, 8'd255}) begin
      fails++;
      $display("FAIL autoreload_abort: count=%0d busy=%b ovf=%0d, expected 0/0/255",
               count, busy, ovf_cnt);
    end
    launch(3'd0, 1'b1);
    tests++;
    if ({count, busy, done, ovf_cnt} !== {3'd0, 1'b1, 1'b0, 8'd0}) begin
      fails++;
      $display("FAIL zero_auto_launch: count=%0d busy=%b done=%b ovf=%0d, expected 0/1/0/0",
               count, busy, done, ovf_cnt);
    end
    for (int i = 1; i <= 2; i++) begin
      cyc();
      tests++;
      if ({count, done, ovf_cnt} !== {3'd0, 1'b1, i[7:0]}) begin
        fails++;
        $display("FAIL zero_auto_t%0d: count=%0d done=%b ovf=%0d, expected 0/1/%0d",
                 i, count, done, ovf_cnt, i);
      end
    end
    stop = 1'b1;
    cyc();
    cyc();
    stop = 1'b0;
  endtask

  task automatic test_pause_resume();
    tick = 1'b1;
    launch(3'd7, 1'b0);
    repeat (3) cyc();
    stop = 1'b1;
    cyc();
    stop = 1'b0;
    load_val = 3'd1;
    for (int i = 0; i < 4; i++) begin
      tests++;
      if ({count, busy, done} !== {3'd3, 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL pause_hold%0d: count=%0d busy=%b done=%b, expected 3/1/0",
                 i, count, busy, done);
      end
      cyc();
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    tests++;
    if ({count, busy} !== {3'd3, 1'b1}) begin
      fails++;
      $display("FAIL resume_edge: count=%0d busy=%b, expected 3/1", count, busy);
    end
    for (int i = 4; i <= 7; i++) begin
      cyc();
      tests++;
      if ({count, busy, done} !== {i[2:0], 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL resume_c%0d: count=%0d busy=%b done=%b, expected %0d/1/0",
                 i, count, busy, done, i);
      end
    end
    cyc();
    tests++;
    if ({count, busy, done} !== {3'd7, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL resume_done: count=%0d busy=%b done=%b, expected 7/0/1", count, busy, done);
    end
    cyc();
    tests++;
    if (done !== 1'b0) begin
      fails++;
      $display("FAIL resume_single: done=%b, expected 0", done);
    end
  endtask

  task automatic test_abort_priority();
    tick = 1'b1;
    launch(3'd6, 1'b0);
    cyc();
    stop = 1'b1;
    cyc();
    tests++;
    if ({count, busy} !== {3'd1, 1'b1}) begin
      fails++;
      $display("FAIL abort_paused: count=%0d busy=%b, expected 1/1", count, busy);
    end
    start = 1'b1;
    cyc();
    start = 1'b0;
    stop  = 1'b0;
    tests++;
    if ({count, busy, done} !== {3'd0, 1'b0, 1'b0}) begin
      fails++;
      $display("FAIL abort_stopwins: count=%0d busy=%b done=%b, expected 0/0/0", count, busy, done);
    end
    launch(3'd4, 1'b0);
    start    = 1'b1;
    load_val = 3'd1;
    for (int i = 1; i <= 4; i++) begin
      if (i == 4) start = 1'b0;
      cyc();
      tests++;
      if ({count, busy, done} !== {i[2:0], 1'b1, 1'b0}) begin
        fails++;
        $display("FAIL ignore_start_c%0d: count=%0d busy=%b done=%b, expected %0d/1/0",
                 i, count, busy, done, i);
      end
    end
    cyc();
    tests++;
    if ({count, busy, done} !== {3'd4, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL ignore_start_done: count=%0d busy=%b done=%b, expected 4/0/1",
               count, busy, done);
    end
    cyc();
  endtask

  task automatic test_tick_gating();
    tick = 1'b0;
    launch(3'd3, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      tick = 1'b0;
      cyc();
      cyc();
      tests++;
      if ({count, done} !== {3'(k - 1), 1'b0}) begin
        fails++;
        $display("FAIL gate_idle%0d: count=%0d done=%b, expected %0d/0", k, count, done, k - 1);
      end
      tick = 1'b1;
      cyc();
      if (k < 4) begin
        tests++;
        if ({count, busy, done} !== {k[2:0], 1'b1, 1'b0}) begin
          fails++;
          $display("FAIL gate_tick%0d: count=%0d busy=%b done=%b, expected %0d/1/0",
                   k, count, busy, done, k);
        end
      end
    end
    tests++;
    if ({count, busy, done} !== {3'd3, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL gate_done: count=%0d busy=%b done=%b, expected 3/0/1", count, busy, done);
    end
    tick = 1'b1;
    cyc();
    launch(3'd0, 1'b0);
    tests++;
    if ({count, busy, done} !== {3'd0, 1'b0, 1'b1}) begin
      fails++;
      $display("FAIL zero_shot: count=%0d busy=%b done=%b, expected 0/0/1", count, busy, done);
    end
    cyc();
    tests++;
    if ({busy, done} !== {1'b0, 1'b0}) begin
      fails++;
      $display("FAIL zero_shot_after: busy=%b done=%b, expected 0/0", busy, done);
    end
  endtask

  initial begin
    res      = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    tick     = 1'b0;
    mode     = 1'b0;
    load_val = '0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_one_shot();
    test_auto_reload();
    test_pause_resume();
    test_abort_priority();
    test_tick_gating();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_count_ctrl
